// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store sequencer: RV32I funct3 values,
// instruction field range, FSM states and the funct3 legality check.
package mem_access_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int IR_FUNCT3_HI = 14;
    localparam int IR_FUNCT3_LO = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    // Stores only have the signed encodings; the unsigned ones are load-only.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_LB, F3_LH, F3_LW: ok = 1'b1;
            F3_LBU, F3_LHU:      ok = !we;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core request/response handshake plus the DataMem port set.
interface mem_access_unit_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_fault;
    logic              dm_read;
    logic              dm_write;
    logic [2:0]        dm_funct3;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               dm_read, dm_write, dm_funct3, dm_addr, dm_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               dm_read, dm_write, dm_funct3, dm_addr, dm_wdata
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Byte-lane assembly and sign/zero extension keyed by load funct3; also
// usable by the writeback mux with lane_sel tied off.
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] asm_in,
    input  logic [7:0]  lane_byte,
    input  logic [1:0]  lane_sel,
    input  logic [2:0]  funct3,
    output logic [31:0] asm_out,
    output logic [31:0] ext_out
);

    // drop the incoming byte into its lane
    always_comb begin
        asm_out = asm_in;
        case (lane_sel)
            2'd0:    asm_out[7:0]   = lane_byte;
            2'd1:    asm_out[15:8]  = lane_byte;
            2'd2:    asm_out[23:16] = lane_byte;
            2'd3:    asm_out[31:24] = lane_byte;
            default: asm_out        = asm_in;
        endcase
    end

    // extend the assembled value to 32 bits
    always_comb begin
        case (funct3)
            F3_LB:   ext_out = {{24{asm_out[7]}}, asm_out[7:0]};
            F3_LH:   ext_out = {{16{asm_out[15]}}, asm_out[15:0]};
            F3_LBU:  ext_out = {24'h000000, asm_out[7:0]};
            F3_LHU:  ext_out = {16'h0000, asm_out[15:0]};
            default: ext_out = asm_out;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of DataMem: aligned accesses take one beat,
// misaligned ones are split into byte beats and reassembled.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_unit_if.slave bus
);

    state_e            state_r, state_s;
    logic              we_r, split_r;
    logic [2:0]        f3_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r, asm_r;
    logic [1:0]        beat_r, last_r;
    logic              req_ready_r, resp_valid_r, resp_fault_r;
    logic [31:0]       resp_rdata_r;

    logic              accept_s, range_bad_s, misalign_s, fault_s, split_s, last_beat_s;
    logic [1:0]        last_idx_s;
    logic [31:0]       asm_s, ext_s;
    logic              dm_read_s, dm_write_s;
    logic [2:0]        dm_funct3_s;
    logic [ADDR_W-1:0] dm_addr_s;
    logic [31:0]       dm_wdata_s;

    // request qualification in the accept cycle
    always_comb begin
        accept_s    = bus.req_valid && req_ready_r;
        range_bad_s = (bus.req_addr >> ADDR_W) != 32'd0;
        misalign_s  = ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)) ||
                      ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]);
        fault_s     = !funct3_legal(bus.req_we, bus.req_funct3) || range_bad_s ||
                      (misalign_s && !MISALIGN_EN);
        split_s     = misalign_s && MISALIGN_EN;
        if (split_s) begin
            last_idx_s = (bus.req_funct3[1:0] == 2'b10) ? 2'd3 : 2'd1;
        end else begin
            last_idx_s = 2'd0;
        end
        last_beat_s = (beat_r == last_r);
    end

    load_extend u_load_extend (
        .asm_in    (asm_r),
        .lane_byte (bus.dm_rdata[7:0]),
        .lane_sel  (beat_r),
        .funct3    (f3_r),
        .asm_out   (asm_s),
        .ext_out   (ext_s)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // next state and DataMem port drive; strobes are gated by rst_n so a
    // reset edge can never commit a write
    always_comb begin
        state_s     = state_r;
        dm_read_s   = 1'b0;
        dm_write_s  = 1'b0;
        dm_funct3_s = split_r ? F3_SB : f3_r;
        dm_addr_s   = addr_r + ADDR_W'(beat_r);
        dm_wdata_s  = split_r ? {24'h000000, wdata_r[{beat_r, 3'b000} +: 8]} : wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = fault_s ? ST_RESP : ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                dm_read_s  = rst_n && !we_r;
                dm_write_s = rst_n && we_r;
                if (last_beat_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // request latch, beat counter, assembly and registered response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_r         <= 1'b0;
            split_r      <= 1'b0;
            f3_r         <= 3'b000;
            addr_r       <= '0;
            wdata_r      <= 32'h0;
            asm_r        <= 32'h0;
            beat_r       <= 2'd0;
            last_r       <= 2'd0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_fault_r <= 1'b0;
            resp_rdata_r <= 32'h0;
        end else begin
            if (accept_s) begin
                we_r    <= bus.req_we;
                split_r <= split_s;
                f3_r    <= bus.req_funct3;
                addr_r  <= bus.req_addr[ADDR_W-1:0];
                wdata_r <= bus.req_wdata;
                last_r  <= last_idx_s;
                beat_r  <= 2'd0;
                asm_r   <= 32'h0;
            end else if (state_r == ST_ACCESS) begin
                beat_r <= beat_r + 2'd1;
                if (!we_r) begin
                    asm_r <= asm_s;
                end else begin
                    asm_r <= asm_r;
                end
            end else begin
                beat_r <= beat_r;
            end

            req_ready_r  <= (state_s == ST_IDLE);
            resp_valid_r <= (state_s == ST_RESP);
            if (accept_s && fault_s) begin
                resp_fault_r <= 1'b1;
                resp_rdata_r <= 32'h0;
            end else if ((state_r == ST_ACCESS) && last_beat_s) begin
                resp_fault_r <= 1'b0;
                resp_rdata_r <= we_r ? 32'h0 : (split_r ? ext_s : bus.dm_rdata);
            end else begin
                resp_fault_r <= 1'b0;
                resp_rdata_r <= 32'h0;
            end
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_fault = resp_fault_r;
    assign bus.dm_read    = dm_read_s;
    assign bus.dm_write   = dm_write_s;
    assign bus.dm_funct3  = dm_funct3_s;
    assign bus.dm_addr    = dm_addr_s;
    assign bus.dm_wdata   = dm_wdata_s;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a byte-addressed DataMem model;
// a second instance with splitting disabled covers the misaligned fault.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        t_sel, t_valid, t_we;
    logic [2:0]  t_f3;
    logic [31:0] t_addr, t_wdata;

    mem_access_unit_if #(.ADDR_W(8)) bus0 ();
    mem_access_unit_if #(.ADDR_W(8)) bus1 ();

    mem_access_unit #(.ADDR_W(8), .MISALIGN_EN(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    mem_access_unit #(.ADDR_W(8), .MISALIGN_EN(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus0.req_valid  = t_valid & ~t_sel;
    assign bus1.req_valid  = t_valid & t_sel;
    assign bus0.req_we     = t_we;
    assign bus1.req_we     = t_we;
    assign bus0.req_funct3 = t_f3;
    assign bus1.req_funct3 = t_f3;
    assign bus0.req_addr   = t_addr;
    assign bus1.req_addr   = t_addr;
    assign bus0.req_wdata  = t_wdata;
    assign bus1.req_wdata  = t_wdata;
    assign bus1.dm_rdata   = 32'h0;

    logic        m_ready, m_rvalid, m_fault, m_read, m_write;
    logic [31:0] m_rdata, m_wdata;
    logic [2:0]  m_f3;
    logic [7:0]  m_addr;
    always_comb begin
        if (t_sel) begin
            m_ready = bus1.req_ready;  m_rvalid = bus1.resp_valid; m_fault = bus1.resp_fault;
            m_rdata = bus1.resp_rdata; m_read = bus1.dm_read;      m_write = bus1.dm_write;
            m_f3    = bus1.dm_funct3;  m_addr = bus1.dm_addr;      m_wdata = bus1.dm_wdata;
        end else begin
            m_ready = bus0.req_ready;  m_rvalid = bus0.resp_valid; m_fault = bus0.resp_fault;
            m_rdata = bus0.resp_rdata; m_read = bus0.dm_read;      m_write = bus0.dm_write;
            m_f3    = bus0.dm_funct3;  m_addr = bus0.dm_addr;      m_wdata = bus0.dm_wdata;
        end
    end

    // DataMem model: combinational extended read, write on the clock edge
    logic [7:0]  mem [0:255];
    logic        mem_clear;
    logic [7:0]  ma0, ma1, ma2, ma3;
    logic [31:0] rb, rd;
    always_comb begin
        ma0 = bus0.dm_addr;
        ma1 = bus0.dm_addr + 8'd1;
        ma2 = bus0.dm_addr + 8'd2;
        ma3 = bus0.dm_addr + 8'd3;
        rb  = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
        case (bus0.dm_funct3)
            3'b000:  rd = {{24{rb[7]}}, rb[7:0]};
            3'b100:  rd = {24'h0, rb[7:0]};
            3'b001:  rd = {{16{rb[15]}}, rb[15:0]};
            3'b101:  rd = {16'h0, rb[15:0]};
            default: rd = rb;
        endcase
    end
    assign bus0.dm_rdata = rd;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[0] <= 8'h0C;
        end else if (bus0.dm_write) begin
            mem[ma0] <= bus0.dm_wdata[7:0];
            if (bus0.dm_funct3 != 3'b000) mem[ma1] <= bus0.dm_wdata[15:8];
            if (bus0.dm_funct3 == 3'b010) begin
                mem[ma2] <= bus0.dm_wdata[23:16];
                mem[ma3] <= bus0.dm_wdata[31:24];
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] r_rdata, r_baddr, r_bdata;
    logic        r_fault;
    logic [2:0]  r_f3;
    int          r_lat, r_nrd, r_nwr;

    // one request; records latency, memory beats and the response
    task automatic do_req(input logic sel, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
        t_sel = sel; t_we = we; t_f3 = f3; t_addr = addr; t_wdata = wdata; t_valid = 1'b1;
        chk("ready_idle", {31'h0, m_ready}, 32'h1);
        r_nrd = 0; r_nwr = 0; r_baddr = 32'h0; r_bdata = 32'h0; r_f3 = 3'b111;
        tick();
        t_valid = 1'b0; t_we = ~we; t_f3 = 3'($urandom); t_addr = $urandom; t_wdata = $urandom;
        r_lat = 1;
        while (!m_rvalid && r_lat < 20) begin
            if (m_read || m_write) begin
                if (r_nrd + r_nwr == 0) r_f3 = m_f3;
                r_baddr = {r_baddr[23:0], m_addr};
                r_bdata = {r_bdata[23:0], m_wdata[7:0]};
            end
            r_nrd += int'(m_read);
            r_nwr += int'(m_write);
            tick();
            r_lat++;
        end
        r_rdata = m_rdata;
        r_fault = m_fault;
        chk("ready_in_resp", {31'h0, m_ready}, 32'h0);
        tick();
        chk("single_pulse", {30'h0, m_rvalid, m_ready}, 32'h1);
    endtask

    logic [31:0] hs_exp [3];
    int          acc_cyc [3];
    int          nacc, nresp, cyc;
    logic        acc_now;

    initial begin
        rst_n = 1'b0; mem_clear = 1'b1;
        t_sel = 1'b0; t_valid = 1'b0; t_we = 1'b0; t_f3 = 3'b000; t_addr = 32'h0; t_wdata = 32'h0;
        tick(); tick();
        chk("rst_ready", {31'h0, m_ready}, 32'h1);
        chk("rst_resp", {30'h0, m_rvalid, m_fault}, 32'h0);
        chk("rst_rdata", m_rdata, 32'h0);
        chk("rst_dm", {30'h0, m_read, m_write}, 32'h0);
        mem_clear = 1'b0; rst_n = 1'b1;
        tick();

        // aligned load
        do_req(1'b0, 1'b0, F3_LW, 32'h00, 32'h0);
        chk("lw0_data", r_rdata, 32'h0000000C);
        chk("lw0_fault", {31'h0, r_fault}, 32'h0);
        chk("lw0_lat", r_lat, 32'd2);
        chk("lw0_beats", {r_nrd[15:0], r_nwr[15:0]}, 32'h00010000);
        chk("lw0_f3", {29'h0, r_f3}, 32'h2);
        chk("lw0_addr", r_baddr, 32'h00000000);

        // misaligned word round trip
        do_req(1'b0, 1'b1, F3_SW, 32'h21, 32'hDEADBEEF);
        chk("sw21_lat", r_lat, 32'd5);
        chk("sw21_beats", {r_nrd[15:0], r_nwr[15:0]}, 32'h00000004);
        chk("sw21_addrs", r_baddr, 32'h21222324);
        chk("sw21_bytes", r_bdata, 32'hEFBEADDE);
        chk("sw21_f3", {29'h0, r_f3}, 32'h0);
        chk("sw21_resp", {r_rdata[30:0], r_fault}, 32'h0);
        do_req(1'b0, 1'b0, F3_LW, 32'h21, 32'h0);
        chk("lw21_data", r_rdata, 32'hDEADBEEF);
        chk("lw21_lat", r_lat, 32'd5);
        chk("lw21_reads", r_nrd, 32'd4);
        do_req(1'b0, 1'b0, F3_LB, 32'h24, 32'h0);
        chk("lb24_data", r_rdata, 32'hFFFFFFDE);
        chk("lb24_lat", r_lat, 32'd2);
        do_req(1'b0, 1'b0, F3_LBU, 32'h24, 32'h0);
        chk("lbu24_data", r_rdata, 32'h000000DE);
        do_req(1'b0, 1'b0, F3_LH, 32'h22, 32'h0);
        chk("lh22_data", r_rdata, 32'hFFFFADBE);

        // halfword wrapping past the top of memory
        do_req(1'b0, 1'b1, F3_SH, 32'hFF, 32'h000080F1);
        chk("shff_lat", r_lat, 32'd3);
        chk("shff_addrs", r_baddr, 32'h0000FF00);
        chk("shff_bytes", r_bdata, 32'h0000F180);
        chk("mem_ff", {24'h0, mem[8'hFF]}, 32'hF1);
        chk("mem_00", {24'h0, mem[8'h00]}, 32'h80);
        do_req(1'b0, 1'b0, F3_LH, 32'hFF, 32'h0);
        chk("lhff_data", r_rdata, 32'hFFFF80F1);
        chk("lhff_lat", r_lat, 32'd3);
        do_req(1'b0, 1'b0, F3_LHU, 32'hFF, 32'h0);
        chk("lhuff_data", r_rdata, 32'h000080F1);

        // faults
        do_req(1'b0, 1'b0, F3_LW, 32'h100, 32'h0);
        chk("oor_resp", {r_rdata[30:0], r_fault}, 32'h1);
        chk("oor_lat", r_lat, 32'd1);
        chk("oor_dm", r_nrd + r_nwr, 32'd0);
        do_req(1'b0, 1'b1, 3'b011, 32'h00, 32'h12345678);
        chk("sf3_resp", {r_rdata[30:0], r_fault}, 32'h1);
        chk("sf3_lat", r_lat, 32'd1);
        chk("sf3_dm", r_nrd + r_nwr, 32'd0);
        chk("sf3_mem", {24'h0, mem[8'h00]}, 32'h80);
        do_req(1'b0, 1'b0, 3'b110, 32'h04, 32'h0);
        chk("lf3_resp", {r_rdata[30:0], r_fault}, 32'h1);
        do_req(1'b1, 1'b0, F3_LW, 32'h02, 32'h0);
        chk("mis_resp", {r_rdata[30:0], r_fault}, 32'h1);
        chk("mis_lat", r_lat, 32'd1);
        chk("mis_dm", r_nrd + r_nwr, 32'd0);
        do_req(1'b1, 1'b0, F3_LW, 32'h00, 32'h0);
        chk("nomis_fault", {31'h0, r_fault}, 32'h0);
        chk("nomis_lat", r_lat, 32'd2);

        // back-to-back handshake with valid held high
        do_req(1'b0, 1'b1, F3_SW, 32'h10, 32'hA1B2C3D4);
        chk("sw10_lat", r_lat, 32'd2);
        chk("sw10_beats", r_nwr, 32'd1);
        do_req(1'b0, 1'b1, F3_SW, 32'h14, 32'h01020304);
        do_req(1'b0, 1'b1, F3_SW, 32'h18, 32'h7F00FF80);
        hs_exp[0] = 32'hA1B2C3D4; hs_exp[1] = 32'h01020304; hs_exp[2] = 32'h7F00FF80;
        nacc = 0; nresp = 0; cyc = 0;
        t_sel = 1'b0; t_we = 1'b0; t_f3 = F3_LW; t_addr = 32'h10; t_valid = 1'b1;
        while (nresp < 3 && cyc < 40) begin
            acc_now = m_ready;
            tick();
            cyc++;
            if (acc_now && nacc < 3) begin
                acc_cyc[nacc] = cyc;
                nacc++;
                if (nacc < 3) t_addr = 32'h10 + 32'(4 * nacc);
                else t_valid = 1'b0;
            end
            if (m_rvalid) begin
                if (nresp < 3) chk("hs_rdata", m_rdata, hs_exp[nresp]);
                nresp++;
            end
        end
        t_valid = 1'b0;
        chk("hs_nresp", nresp, 32'd3);
        chk("hs_nacc", nacc, 32'd3);
        chk("hs_gap1", acc_cyc[1] - acc_cyc[0], 32'd3);
        chk("hs_gap2", acc_cyc[2] - acc_cyc[1], 32'd3);
        tick();
        chk("hs_quiet", {31'h0, m_rvalid}, 32'h0);

        // reset during beat 2 of a split store
        t_sel = 1'b0; t_we = 1'b1; t_f3 = F3_SW; t_addr = 32'h41; t_wdata = 32'h11223344; t_valid = 1'b1;
        tick();
        t_valid = 1'b0;
        chk("rst_b0", {23'h0, m_write, m_addr}, 32'h141);
        tick();
        chk("rst_b1", {23'h0, m_write, m_addr}, 32'h142);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mask", {31'h0, m_write}, 32'h0);
        tick();
        rst_n = 1'b1;
        chk("rst_norsp", {31'h0, m_rvalid}, 32'h0);
        tick();
        chk("rst_rel", {30'h0, m_rvalid, m_ready}, 32'h1);
        chk("rst_m41", {24'h0, mem[8'h41]}, 32'h44);
        chk("rst_m42", {24'h0, mem[8'h42]}, 32'h33);
        chk("rst_m43", {24'h0, mem[8'h43]}, 32'h00);
        chk("rst_m44", {24'h0, mem[8'h44]}, 32'h00);
        tick();
        chk("rst_quiet", {30'h0, m_rvalid, m_write}, 32'h0);
        do_req(1'b0, 1'b0, F3_LBU, 32'h43, 32'h0);
        chk("rst_lbu43", r_rdata, 32'h00000000);
        chk("rst_lbu_lat", r_lat, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store sequencer sitting directly upstream of the byte-addressed data memory (DataMem). It accepts one load/store request from the core via a valid/ready handshake and drives the memory's MemRead/MemWrite/funct3/addr/data_in port set. Aligned accesses complete in one memory beat. Misaligned halfword/word accesses are split into byte beats, then reassembled with sign or zero extension. It returns a single-cycle response carrying load data or a fault flag.

Parameters:
ADDR_W, 8, width of memory address driven to DataMem; request addresses at or above 2**ADDR_W fault.
MISALIGN_EN, 1, 1 = split misaligned accesses into byte beats; 0 = misaligned access faults.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  synchronous active-low reset.
req_valid  input  1  core request valid.
req_ready  output  1  unit can accept a request; high only in IDLE.
req_we  input  1  1 = store, 0 = load.
req_funct3  input  3  RV32I load/store funct3.
req_addr  input  32  byte address.
req_wdata  input  32  store data.
resp_valid  output  1  one-cycle response strobe.
resp_rdata  output  32  extended load data; 0 for stores and faults.
resp_fault  output  1  out-of-range address, illegal funct3, or misaligned access with MISALIGN_EN=0.
dm_read  output  1  to DataMem MemRead.
dm_write  output  1  to DataMem MemWrite.
dm_funct3  output  3  to DataMem funct3.
dm_addr  output  ADDR_W  to DataMem addr.
dm_wdata  output  32  to DataMem data_in.
dm_rdata  input  32  from DataMem data_out (combinational read).

Behaviour:
- Clocking and reset: single clock domain; rst_n is synchronous and active-low.
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, beat counter=0, assembly register=0.
- dm_read/dm_write are combinationally ANDed with rst_n, so no write occurs on a reset edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Accept on req_valid&&req_ready; latch we, funct3, addr, wdata.
  - Legal loads: funct3 in {000, 001, 010, 100, 101}. Legal stores: {000, 001, 010}.
  - Fault when: funct3 is illegal; req_addr[31:ADDR_W] != 0; or the access is misaligned with MISALIGN_EN=0.
  - Fault -> RESP with fault=1. Otherwise -> ACCESS, beat=0.
- Alignment:
  - Word is aligned iff addr[1:0]==0; half iff addr[0]==0; byte always.
  - Aligned access: 1 beat, dm_funct3=latched funct3.
  - Misaligned access: 4 beats (word) or 2 beats (half). Each beat uses dm_funct3=000 (LB/SB), dm_addr=addr+beat modulo 2**ADDR_W (wraps 0xFF->0x00).
  - Store beat i drives dm_wdata[7:0]=wdata[8i+7:8i].
  - Load beat i captures dm_rdata[7:0] into assembly byte lane i at the clock edge.
- ACCESS:
  - dm_read=!we, dm_write=we for exactly one cycle per beat; both are 0 in every other state.
  - After the last beat -> RESP.
- Result assembly:
  - Aligned loads register dm_rdata as-is (DataMem has already extended it).
  - Split loads extend the assembled value per latched funct3: 001 sign from bit15, 101 zero, 010 none.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0, then -> IDLE.
- Latency from accept edge: fault -> resp next cycle; aligned -> 2 cycles; misaligned half -> 3; misaligned word -> 5. Back-to-back throughput is one request per (latency+1) cycles.
- req_* changes outside the accept cycle are ignored.
- Reset mid-ACCESS:
  - Bytes written on earlier beats remain written; no further beats are issued.
  - No response is produced; the unit is in IDLE and ready the cycle after reset is released.

Decomposition:
- Shared defines include: funct3 encodings (LB/LH/LW/LBU/LHU/SB/SH/SW), the `IR_funct3 field range, and FSM state encodings.
- One natural sub-module, load_extend: combinational byte-lane assembly plus sign/zero extension keyed by funct3. It is reusable by the writeback mux.

Test Plan:
- Aligned load: after reset, LW req_addr=0x00 against memory pre-loaded with mem[0]=12 -> dm_read high 1 cycle at addr 0x00, funct3=010; resp_valid 2 cycles after accept, rdata=0x0000000C, fault=0.
- Misaligned word round trip: SW 0xDEADBEEF @0x21 -> 4 SB beats at addrs 0x21..0x24 carrying EF, BE, AD, DE; then LW @0x21 -> rdata=0xDEADBEEF at 5 cycles; LB @0x24 -> 0xFFFFFFDE; LBU @0x24 -> 0x000000DE.
- Wrap-around: SH 0x80F1 @0xFF -> bytes F1@0xFF, 80@0x00; LH @0xFF -> 0xFFFF80F1; LHU @0xFF -> 0x000080F1.
- Faults: LW @0x100, store funct3=011, and LW @0x02 with MISALIGN_EN=0 -> each gives resp_fault=1, rdata=0, resp 1 cycle after accept, dm_read=dm_write=0 throughout.
- Reset mid-operation: assert rst_n=0 during beat 2 of SW 0x11223344 @0x41 -> only 0x44@0x41 and 0x33@0x42 written; no resp_valid; req_ready=1 the cycle after release; a following LBU @0x43 returns the old value.
- Handshake: hold req_valid high with 3 queued aligned LWs -> each accepted only while req_ready=1, responses in order, exactly one resp_valid pulse per request.
